// File: rtl/defines_pkg.sv
// defines_pkg: opcodes, widths, stage types and instruction-word layout for SPU-lite
// Shared by spu_regfile and spu_pipes_top; no ports.
package defines_pkg;
    localparam int ADDR_W   = 7;
    localparam int QW_W     = 128;
    localparam int REG_N    = 128;
    localparam int RD_PORTS = 6;

    localparam int    NUM_INS     = 64;
    localparam string EVENINSFILE = "even_ins.txt";
    localparam string ODDINSFILE  = "odd_ins.txt";

    // instruction-word field layout
    localparam int OPC_MSB = 56, OPC_LSB = 46;
    localparam int I18_MSB = 45, I18_LSB = 28;
    localparam int RA_MSB  = 27, RA_LSB  = 21;
    localparam int RB_MSB  = 20, RB_LSB  = 14;
    localparam int RC_MSB  = 13, RC_LSB  = 7;
    localparam int RT_MSB  = 6,  RT_LSB  = 0;

    typedef enum logic [10:0] {
        LNOP    = 11'b00000000001,
        NOP     = 11'b01000000001,
        A       = 11'b00011000000,
        SF      = 11'b00001000000,
        AND     = 11'b00011000001,
        OR      = 11'b00001000001,
        XOR     = 11'b01001000001,
        AI      = 11'b00011100000,
        IL      = 11'b01000000100,
        SHLQBYI = 11'b00111111111,
        ROTQBYI = 11'b00111111100,
        BR      = 11'b00110010000,
        BRA     = 11'b00110000000
    } Opcodes;

    typedef struct packed {
        Opcodes            opc;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic [ADDR_W-1:0] rc;
        logic [ADDR_W-1:0] rt;
        logic [6:0]        i7;
        logic [9:0]        i10;
        logic [15:0]       i16;
    } issue_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] rt;
        logic [0:QW_W-1]   res;
    } stage_t;

    function automatic issue_t idle_iss(input Opcodes op);
        idle_iss = '0;
        idle_iss.opc = op;
    endfunction

    // Only one result age is ever in flight, so the odd stage simply outranks the even one.
    function automatic logic [0:QW_W-1] fwd(input logic [ADDR_W-1:0] a, input logic [0:QW_W-1] rf,
                                            input stage_t e, input stage_t o);
        return (o.we && o.rt == a) ? o.res : (e.we && e.rt == a) ? e.res : rf;
    endfunction
endpackage

// File: rtl/spu_regfile.sv
// spu_regfile: 128 x 128-bit register file, 6 combinational reads, 2 writes, async clear
// Ports: clk, rst_n (async active-low clear), i_rd_addr/o_rd_data (6 read ports),
//        i_we_e/i_wa_e/i_wd_e (even write), i_we_o/i_wa_o/i_wd_o (odd write, wins on collision).
module spu_regfile
    import defines_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_rd_addr [RD_PORTS],
    output logic [0:QW_W-1]   o_rd_data [RD_PORTS],
    input  logic              i_we_e,
    input  logic [ADDR_W-1:0] i_wa_e,
    input  logic [0:QW_W-1]   i_wd_e,
    input  logic              i_we_o,
    input  logic [ADDR_W-1:0] i_wa_o,
    input  logic [0:QW_W-1]   i_wd_o
);
    logic [0:QW_W-1] regs [REG_N];

    // odd write placed last so it takes the entry when both target the same register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) regs[i] <= '0;
        end else begin
            if (i_we_e) regs[i_wa_e] <= i_wd_e;
            if (i_we_o) regs[i_wa_o] <= i_wd_o;
        end
    end

    always_comb for (int i = 0; i < RD_PORTS; i++) o_rd_data[i] = regs[i_rd_addr[i]];
endmodule

// File: rtl/spu_pipes_top.sv
// spu_pipes_top: SPU-lite dual-issue execute core (even ALU pipe, odd byte-shift/branch pipe)
// Ports: clk, rst (async active-low), opcode_ep/opcode_op, r{a,b,c,t}_addr_{ep,op},
//        in_I{7,8,10,16,18}{e,o} immediates, PC_in (current pair PC), PC_out (registered next PC).
module spu_pipes_top
    import defines_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  Opcodes            opcode_ep,
    input  Opcodes            opcode_op,
    input  logic [ADDR_W-1:0] ra_addr_ep,
    input  logic [ADDR_W-1:0] rb_addr_ep,
    input  logic [ADDR_W-1:0] rc_addr_ep,
    input  logic [ADDR_W-1:0] rt_addr_ep,
    input  logic [ADDR_W-1:0] ra_addr_op,
    input  logic [ADDR_W-1:0] rb_addr_op,
    input  logic [ADDR_W-1:0] rc_addr_op,
    input  logic [ADDR_W-1:0] rt_addr_op,
    input  logic [6:0]        in_I7e,
    input  logic [7:0]        in_I8e,
    input  logic [9:0]        in_I10e,
    input  logic [15:0]       in_I16e,
    input  logic [17:0]       in_I18e,
    input  logic [6:0]        in_I7o,
    input  logic [7:0]        in_I8o,
    input  logic [9:0]        in_I10o,
    input  logic [15:0]       in_I16o,
    input  logic [17:0]       in_I18o,
    input  logic [0:31]       PC_in,
    output logic [0:31]       PC_out
);
    issue_t            r_iss_e, r_iss_o;
    stage_t            r_stg_e, r_stg_o;
    logic [0:31]       r_pc;
    logic [ADDR_W-1:0] w_rd_addr [RD_PORTS];
    logic [0:QW_W-1]   w_rd_data [RD_PORTS];
    logic [0:QW_W-1]   w_ra_e, w_rb_e, w_ra_o, w_res_e, w_res_o, w_shl, w_rot;
    logic [0:2*QW_W-1] w_dbl;
    logic [31:0]       w_i10e, w_i16e;
    logic [0:31]       w_off, w_pc_nxt;
    logic              w_we_e, w_we_o, w_unused;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_iss_e <= idle_iss(NOP);
            r_iss_o <= idle_iss(LNOP);
            r_pc    <= '0;
            r_stg_e <= '0;
            r_stg_o <= '0;
            PC_out  <= '0;
        end else begin
            r_iss_e <= '{opcode_ep, ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep, in_I7e, in_I10e, in_I16e};
            r_iss_o <= '{opcode_op, ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op, in_I7o, in_I10o, in_I16o};
            r_pc    <= PC_in;
            r_stg_e <= '{w_we_e, r_iss_e.rt, w_res_e};
            r_stg_o <= '{w_we_o, r_iss_o.rt, w_res_o};
            PC_out  <= w_pc_nxt;
        end
    end

    assign w_rd_addr = '{r_iss_e.ra, r_iss_e.rb, r_iss_e.rc, r_iss_o.ra, r_iss_o.rb, r_iss_o.rc};

    spu_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data),
        .i_we_e    (r_stg_e.we),
        .i_wa_e    (r_stg_e.rt),
        .i_wd_e    (r_stg_e.res),
        .i_we_o    (r_stg_o.we),
        .i_wa_o    (r_stg_o.rt),
        .i_wd_o    (r_stg_o.res)
    );

    // the stage registers hold results one edge ahead of the register file
    assign w_ra_e = fwd(r_iss_e.ra, w_rd_data[0], r_stg_e, r_stg_o);
    assign w_rb_e = fwd(r_iss_e.rb, w_rd_data[1], r_stg_e, r_stg_o);
    assign w_ra_o = fwd(r_iss_o.ra, w_rd_data[3], r_stg_e, r_stg_o);

    assign w_i10e = {{22{r_iss_e.i10[9]}}, r_iss_e.i10};
    assign w_i16e = {{16{r_iss_e.i16[15]}}, r_iss_e.i16};
    assign w_we_e = r_iss_e.opc inside {A, SF, AND, OR, XOR, AI, IL};

    for (genvar k = 0; k < 4; k++) begin : g_word
        logic [31:0] w_a, w_b;
        assign w_a = w_ra_e[32*k +: 32];
        assign w_b = w_rb_e[32*k +: 32];
        assign w_res_e[32*k +: 32] = r_iss_e.opc == A   ? w_a + w_b :
                                     r_iss_e.opc == SF  ? w_b - w_a :
                                     r_iss_e.opc == AND ? w_a & w_b :
                                     r_iss_e.opc == OR  ? w_a | w_b :
                                     r_iss_e.opc == XOR ? w_a ^ w_b :
                                     r_iss_e.opc == AI  ? w_a + w_i10e :
                                     r_iss_e.opc == IL  ? w_i16e : '0;
    end

    // rotate: shift a doubled copy and keep the upper quadword
    assign w_dbl   = {w_ra_o, w_ra_o} << {r_iss_o.i7[3:0], 3'b000};
    assign w_rot   = w_dbl[0:QW_W-1];
    assign w_shl   = r_iss_o.i7[4] ? '0 : w_ra_o << {r_iss_o.i7[3:0], 3'b000};
    assign w_we_o  = r_iss_o.opc inside {SHLQBYI, ROTQBYI};
    assign w_res_o = r_iss_o.opc == SHLQBYI ? w_shl : w_rot;

    assign w_off    = {{14{r_iss_o.i16[15]}}, r_iss_o.i16, 2'b00};
    assign w_pc_nxt = r_iss_o.opc == BR  ? r_pc + w_off :
                      r_iss_o.opc == BRA ? w_off : r_pc + 32'd4;

    assign w_unused = ^{in_I8e, in_I18e, in_I8o, in_I18o, r_iss_e.i7, r_iss_o.i10, r_iss_o.i7[6:5],
                        w_rd_data[2], w_rd_data[4], w_rd_data[5]};
endmodule

// File: tb/tb_spu_pipes_top.sv
// tb_spu_pipes_top: scoreboard bench for the SPU-lite dual-issue core
module tb_spu_pipes_top;
    import defines_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    Opcodes      opcode_ep, opcode_op;
    logic [6:0]  ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep;
    logic [6:0]  ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op;
    logic [6:0]  in_I7e, in_I7o;
    logic [7:0]  in_I8e, in_I8o;
    logic [9:0]  in_I10e, in_I10o;
    logic [15:0] in_I16e, in_I16o;
    logic [17:0] in_I18e, in_I18o;
    logic [0:31] PC_in, PC_out;

    spu_pipes_top dut (
        .clk(clk), .rst(rst), .opcode_ep(opcode_ep), .opcode_op(opcode_op),
        .ra_addr_ep(ra_addr_ep), .rb_addr_ep(rb_addr_ep), .rc_addr_ep(rc_addr_ep), .rt_addr_ep(rt_addr_ep),
        .ra_addr_op(ra_addr_op), .rb_addr_op(rb_addr_op), .rc_addr_op(rc_addr_op), .rt_addr_op(rt_addr_op),
        .in_I7e(in_I7e), .in_I8e(in_I8e), .in_I10e(in_I10e), .in_I16e(in_I16e), .in_I18e(in_I18e),
        .in_I7o(in_I7o), .in_I8o(in_I8o), .in_I10o(in_I10o), .in_I16o(in_I16o), .in_I18o(in_I18o),
        .PC_in(PC_in), .PC_out(PC_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        bit           is_pc;
        int           idx;
        logic [0:127] val;
        int           due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [0:127] R6 = 128'h000102030405060708090A0B0C0D0E0F;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [0:127] got, input logic [0:127] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [0:127] w4(input logic [31:0] w);
        return {4{w}};
    endfunction

    function automatic logic [0:127] all_or();
        logic [0:127] a = '0;
        for (int i = 0; i < 128; i++) a |= dut.u_regfile.regs[i];
        return a;
    endfunction

    // results land in the regfile two edges after issue, PC_out one edge after
    always @(negedge clk)
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].due == cyc) begin
                chk(q[i].tag, q[i].is_pc ? 128'(PC_out) : dut.u_regfile.regs[q[i].idx], q[i].val);
                q.delete(i);
            end

    task automatic idle();
        opcode_ep = NOP; opcode_op = LNOP;
        ra_addr_ep = '0; rb_addr_ep = '0; rc_addr_ep = '0; rt_addr_ep = '0;
        ra_addr_op = '0; rb_addr_op = '0; rc_addr_op = '0; rt_addr_op = '0;
        in_I7e = '0; in_I8e = '0; in_I10e = '0; in_I16e = '0; in_I18e = '0;
        in_I7o = '0; in_I8o = '0; in_I10o = '0; in_I16o = '0; in_I18o = '0;
    endtask

    task automatic ev(input Opcodes op, input int rt, input int ra, input int rb, input logic [15:0] imm);
        opcode_ep = op; rt_addr_ep = 7'(rt); ra_addr_ep = 7'(ra); rb_addr_ep = 7'(rb);
        in_I10e = imm[9:0]; in_I16e = imm;
    endtask

    task automatic od(input Opcodes op, input int rt, input int ra, input logic [15:0] imm);
        opcode_op = op; rt_addr_op = 7'(rt); ra_addr_op = 7'(ra);
        in_I7o = imm[6:0]; in_I16o = imm;
    endtask

    task automatic want(input string tag, input int idx, input logic [0:127] v);
        q.push_back(exp_t'{tag, 1'b0, idx, v, cyc + 3});
    endtask

    task automatic want_pc(input string tag, input logic [31:0] v);
        q.push_back(exp_t'{tag, 1'b1, 0, 128'(v), cyc + 2});
    endtask

    task automatic go();
        logic [31:0] off, nxt;
        off = {{14{in_I16o[15]}}, in_I16o, 2'b00};
        nxt = opcode_op == BR ? PC_in + off : opcode_op == BRA ? off : PC_in + 32'd4;
        want_pc($sformatf("pc@%0d", cyc), nxt);
        @(posedge clk); #1;
        idle();
        PC_in = PC_in + 32'd4;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", 128'(q.size()), '0);
        q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: run did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        PC_in = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", 128'(PC_out), '0);
        chk("rst_regs", all_or(), '0);
        rst = 1'b1;
        PC_in = 32'h200;

        ev(IL, 1, 0, 0, 16'hFFFF);   want("il_r1", 1, w4(32'hFFFFFFFF)); want_pc("pc_plus4", 32'h204); go();
        ev(AI, 2, 1, 0, 16'd2);      want("ai_fwd_wrap", 2, w4(32'h1)); go();
        ev(IL, 3, 0, 0, 16'h000F);   go();
        ev(IL, 4, 0, 0, 16'h00F0);   go();
        ev(OR, 8, 3, 4, 0);          want("or", 8, w4(32'hFF)); go();
        ev(XOR, 9, 3, 4, 0);         want("xor", 9, w4(32'hFF)); go();
        ev(AND, 10, 3, 4, 0);        want("and", 10, w4(32'h0)); go();
        ev(SF, 5, 3, 4, 0);          want("sf", 5, w4(32'hE1)); go();
        ev(SF, 16, 4, 3, 0);         want("sf_neg", 16, w4(32'hFFFFFF1F)); go();

        // build r6 = 00 01 02 .. 0F from word-replicated immediates
        ev(IL, 20, 0, 0, 16'h0001);  go();
        ev(IL, 21, 0, 0, 16'h0203);  go();
        od(SHLQBYI, 20, 20, 2);      go();
        ev(OR, 22, 20, 21, 0);       want("base", 22, w4(32'h00010203)); go();
        ev(IL, 23, 0, 0, 16'h0404);  go();
        od(SHLQBYI, 24, 23, 2);      go();
        ev(OR, 25, 23, 24, 0);       want("step", 25, w4(32'h04040404)); go();
        od(SHLQBYI, 26, 25, 4);      go();
        od(ROTQBYI, 26, 26, 12);     go();
        od(SHLQBYI, 27, 25, 8);      go();
        od(ROTQBYI, 27, 27, 8);      go();
        od(SHLQBYI, 28, 25, 12);     go();
        od(ROTQBYI, 28, 28, 4);      want("one_word", 28, {96'h0, 32'h04040404}); go();
        ev(A, 29, 26, 27, 0);        go();
        ev(A, 29, 29, 28, 0);        go();
        ev(A, 6, 22, 29, 0);         want("r6", 6, R6); go();

        od(SHLQBYI, 11, 6, 1);       want("shl1", 11, 128'h0102030405060708090A0B0C0D0E0F00); go();
        od(ROTQBYI, 12, 6, 1);       want("rot1", 12, 128'h0102030405060708090A0B0C0D0E0F00); go();
        od(SHLQBYI, 13, 6, 16);      want("shl16", 13, '0); go();
        od(ROTQBYI, 14, 6, 5);       want("rot5", 14, 128'h05060708090A0B0C0D0E0F0001020304); go();
        od(SHLQBYI, 17, 6, 31);      want("shl31", 17, '0); go();
        od(SHLQBYI, 18, 6, 15);      want("shl15", 18, 128'h0F000000000000000000000000000000); go();
        od(ROTQBYI, 19, 6, 16);      want("rot16", 19, R6); go();

        PC_in = 32'h100;      od(BR, 0, 0, 16'hFFFF);  want_pc("br_back", 32'hFC); go();
        PC_in = 32'h500;      od(BRA, 0, 0, 16'h0010); want_pc("bra", 32'h40); go();
        PC_in = 32'h0;        od(BR, 0, 0, 16'h8000);  want_pc("br_min", 32'hFFFE0000); go();
        PC_in = 32'hFFFFFFFC; od(BR, 0, 0, 16'h0001);  want_pc("br_wrap", 32'h0); go();

        ev(IL, 7, 0, 0, 16'h1234); od(ROTQBYI, 7, 6, 2);
        want("collide", 7, 128'h02030405060708090A0B0C0D0E0F0001); go();
        ev(A, 15, 7, 7, 0);
        want("fwd_same_age", 15, 128'h0406080A0C0E10121416181A1C1E0002); go();
        drain();

        // reset while r30's result sits in the stage register
        ev(IL, 30, 0, 0, 16'h5555);
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        chk("mid_rst_pc", 128'(PC_out), '0);
        chk("mid_rst_regs", all_or(), '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("no_late_write", dut.u_regfile.regs[30], '0);
        chk("post_rst_regs", all_or(), '0);
        PC_in = 32'h300; want_pc("pc_after_rst", 32'h304); go();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
